// File: rtl/sd_drive_arbiter_pkg.sv
// sd_arb_pkg: shared constants for the SD drive arbiter.
//   - FSM state encoding (legacy-compatible 3-bit localparams)
//   - SD block-port widths: LBA (sector number) and buffer data byte
package sd_arb_pkg;

    localparam int LBA_W = 32;
    localparam int BUF_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_XFER = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/sd_drive_arbiter_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level into clk_sys.
// Ports:
//   clk_sys  destination clock
//   reset    synchronous active-high reset, clears both stages
//   d        asynchronous input level
//   q        synchronised output, 2 clk_sys edges behind d
module sync2 (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s_p0;
    logic s_p1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s_p0 <= 1'b0;
            s_p1 <= 1'b0;
        end else begin
            // stage 0: metastability catch
            s_p0 <= d;
            // stage 1: settled copy
            s_p1 <= s_p0;
        end
    end

    assign q = s_p1;

endmodule

// File: rtl/sd_drive_arbiter.sv
// sd_drive_arbiter: shares the single SD block port of the I/O controller
// among NDRV virtual drives. One sector request is granted at a time in
// round-robin order; the sd_rd/sd_wr/sd_ack handshake is sequenced here and
// buffer traffic is steered to the granted drive. Per-drive mount state is
// tracked from the image-mount strobe.
// Ports:
//   clk_sys, reset          single clock, synchronous active-high reset
//   req_rd/req_wr           per-drive request levels, held until done/err
//   req_lba                 per-drive sector number, 32 bits per drive
//   req_buff_din            per-drive buffer bytes for card writes
//   req_ack                 high while drive i is in its data transfer
//   req_done/req_err        one-cycle completion / abort pulses
//   drv_buff_wr             sd_buff_wr gated to the granted drive
//   drv_ready               drive has a non-empty image mounted
//   drv_mounted             one-cycle pulse on a mount event
//   sd_lba/sd_rd/sd_wr      request side of the I/O controller port
//   sd_ack                  I/O controller acknowledge (asynchronous)
//   sd_buff_wr              buffer write strobe (clk_sys synchronous)
//   sd_buff_din             buffer byte of the granted drive
//   img_mounted/img_size    asynchronous mount strobe and image size
//   mount_drv               drive targeted by the mount event
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NDRV    = 2,
    parameter int TIMEOUT = 2**24,
    parameter int DW      = $clog2(NDRV)
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NDRV-1:0]         req_rd,
    input  logic [NDRV-1:0]         req_wr,
    input  logic [LBA_W*NDRV-1:0]   req_lba,
    input  logic [BUF_W*NDRV-1:0]   req_buff_din,
    output logic [NDRV-1:0]         req_ack,
    output logic [NDRV-1:0]         req_done,
    output logic [NDRV-1:0]         req_err,
    output logic [NDRV-1:0]         drv_buff_wr,
    output logic [NDRV-1:0]         drv_ready,
    output logic [NDRV-1:0]         drv_mounted,
    output logic [LBA_W-1:0]        sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic                    sd_buff_wr,
    output logic [BUF_W-1:0]        sd_buff_din,
    input  logic                    img_mounted,
    input  logic [31:0]             img_size,
    input  logic [DW-1:0]           mount_drv
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]       state;
    logic [DW-1:0]    sel;
    logic [DW-1:0]    last;
    logic [CW-1:0]    cnt;

    logic             ack_s;
    logic             mnt_s;
    logic             mnt_q;

    logic [NDRV-1:0]  cand;
    logic             found;
    logic [DW-1:0]    pick;
    logic [DW-1:0]    idx;
    logic [LBA_W-1:0] lba_pick;

    sync2 u_sync_ack (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (sd_ack),
        .q       (ack_s)
    );

    sync2 u_sync_mnt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (img_mounted),
        .q       (mnt_s)
    );

    assign cand = req_rd | req_wr;

    // Round-robin search: start one past the last grant and wrap, so the
    // drive just served has the lowest priority on the next pass.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = last;
        for (int k = 0; k < NDRV; k++) begin
            idx = (idx == DW'(NDRV - 1)) ? '0 : idx + 1'b1;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        lba_pick    = '0;
        sd_buff_din = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (pick == DW'(i)) lba_pick = req_lba[i*LBA_W +: LBA_W];
            if (sel == DW'(i))  sd_buff_din = req_buff_din[i*BUF_W +: BUF_W];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= ST_IDLE;
            sel    <= '0;
            last   <= DW'(NDRV - 1);
            cnt    <= '0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
            sd_lba <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        sel  <= pick;
                        last <= pick;
                        // drv_ready here is the pre-mount-update value, so a
                        // mount landing on this same edge does not affect it.
                        if (!drv_ready[pick]) begin
                            state <= ST_ERR;
                        end else begin
                            sd_lba <= lba_pick;
                            // read wins when both levels are high
                            sd_rd  <= req_rd[pick];
                            sd_wr  <= ~req_rd[pick];
                            cnt    <= '0;
                            state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= ST_XFER;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= ST_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!ack_s) state <= ST_DONE;
                end
                ST_DONE, ST_ERR: state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end

    // Mount tracking runs independently of the FSM: remounting the drive
    // that is mid-transfer only changes its ready flag, never the transfer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            drv_ready   <= '0;
            drv_mounted <= '0;
            mnt_q       <= 1'b0;
        end else begin
            mnt_q       <= mnt_s;
            drv_mounted <= '0;
            if (mnt_s && !mnt_q && (int'(mount_drv) < NDRV)) begin
                drv_ready[mount_drv]   <= (img_size != 32'd0);
                drv_mounted[mount_drv] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NDRV; i++) begin : g_drv
        assign req_ack[i]     = (state == ST_XFER) && (sel == DW'(i));
        assign req_done[i]    = (state == ST_DONE) && (sel == DW'(i));
        assign req_err[i]     = (state == ST_ERR)  && (sel == DW'(i));
        assign drv_buff_wr[i] = sd_buff_wr && (state == ST_XFER) && (sel == DW'(i));
    end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Testbench for sd_drive_arbiter with NDRV=2 and TIMEOUT=100.
module tb_sd_drive_arbiter;

    localparam int NDRV = 2;
    localparam int TMO  = 100;

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset;
    logic [1:0]  req_rd, req_wr;
    logic [63:0] req_lba;
    logic [15:0] req_buff_din;
    logic [1:0]  req_ack, req_done, req_err, drv_buff_wr, drv_ready, drv_mounted;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        img_mounted;
    logic [31:0] img_size;
    logic [0:0]  mount_drv;

    int checks   = 0;
    int failures = 0;

    sd_drive_arbiter #(.NDRV(NDRV), .TIMEOUT(TMO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_buff_din (req_buff_din),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .drv_buff_wr  (drv_buff_wr),
        .drv_ready    (drv_ready),
        .drv_mounted  (drv_mounted),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .mount_drv    (mount_drv)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  rd;
        logic        ack;
        logic        bwr;
        logic        mnt;
        logic        e_rd;
        logic [31:0] e_lba;
        logic [1:0]  e_ack;
        logic [1:0]  e_done;
        logic [1:0]  e_rdy;
        logic [1:0]  e_bwr;
        logic [1:0]  e_mnt;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic rst, input logic [1:0] rd, input logic ack,
                                input logic bwr, input logic mnt, input logic e_rd,
                                input logic [31:0] e_lba, input logic [1:0] e_ack,
                                input logic [1:0] e_done, input logic [1:0] e_rdy,
                                input logic [1:0] e_bwr, input logic [1:0] e_mnt);
        vec_t v;
        v.rst = rst; v.rd = rd; v.ack = ack; v.bwr = bwr; v.mnt = mnt;
        v.e_rd = e_rd; v.e_lba = e_lba; v.e_ack = e_ack; v.e_done = e_done;
        v.e_rdy = e_rdy; v.e_bwr = e_bwr; v.e_mnt = e_mnt;
        return v;
    endfunction

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic cond(input int w);
        case (w)
            0:       return sd_rd | sd_wr;
            1:       return |req_ack;
            2:       return |req_done;
            default: return |req_err;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w, input int lim, output int n);
        n = 0;
        while (!cond(w) && n < lim) begin
            step;
            n++;
        end
        chk(name, 32'(cond(w)), 32'd1);
    endtask

    task automatic do_xfer(input string nm, input logic [31:0] lba, input logic [1:0] oh);
        int n;
        wait_for({nm, "_grant"}, 0, 8, n);
        chk({nm, "_lba"}, sd_lba, lba);
        sd_ack = 1'b1;
        wait_for({nm, "_ack"}, 1, 8, n);
        chk({nm, "_ackdrv"}, 32'(req_ack), 32'(oh));
        sd_ack = 1'b0;
        wait_for({nm, "_done"}, 2, 8, n);
        chk({nm, "_donedrv"}, 32'(req_done), 32'(oh));
    endtask

    task automatic mount(input logic d, input logic [31:0] sz);
        img_size    = sz;
        mount_drv   = d;
        img_mounted = 1'b1;
        repeat (4) step;
        img_mounted = 1'b0;
        repeat (3) step;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, c0, c1;
        logic never, prev_rd;

        reset        = 1'b1;
        req_rd       = '0;
        req_wr       = '0;
        req_lba      = {32'h0000_0034, 32'h0000_0012};
        req_buff_din = {8'hA5, 8'h11};
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        img_mounted  = 1'b0;
        img_size     = 32'h000B_4000;
        mount_drv    = 1'b0;

        //            rst rd    ack bwr mnt | rd lba       ack    done   rdy    bwr    mnt
        tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 32'h00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[1]  = mk(0, 2'b00, 0, 0, 1, 0, 32'h00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[2]  = mk(0, 2'b00, 0, 0, 1, 0, 32'h00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[3]  = mk(0, 2'b00, 0, 0, 1, 0, 32'h00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        tbl[4]  = mk(0, 2'b00, 0, 0, 0, 0, 32'h00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[5]  = mk(0, 2'b01, 0, 0, 0, 1, 32'h12, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[6]  = mk(0, 2'b01, 1, 0, 0, 1, 32'h12, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[7]  = mk(0, 2'b01, 1, 0, 0, 1, 32'h12, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[8]  = mk(0, 2'b01, 1, 0, 0, 0, 32'h12, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[9]  = mk(0, 2'b01, 1, 1, 0, 0, 32'h12, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        tbl[10] = mk(0, 2'b01, 0, 0, 0, 0, 32'h12, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[11] = mk(0, 2'b01, 0, 0, 0, 0, 32'h12, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[12] = mk(0, 2'b01, 0, 0, 0, 0, 32'h12, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        tbl[13] = mk(0, 2'b00, 0, 0, 0, 0, 32'h12, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        tbl[14] = mk(0, 2'b00, 0, 1, 0, 0, 32'h12, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);

        for (int r = 0; r < 15; r++) begin
            reset       = tbl[r].rst;
            req_rd      = tbl[r].rd;
            sd_ack      = tbl[r].ack;
            sd_buff_wr  = tbl[r].bwr;
            img_mounted = tbl[r].mnt;
            step;
            chk($sformatf("v%0d_sd_rd", r),   32'(sd_rd),       32'(tbl[r].e_rd));
            chk($sformatf("v%0d_sd_wr", r),   32'(sd_wr),       32'd0);
            chk($sformatf("v%0d_sd_lba", r),  sd_lba,           tbl[r].e_lba);
            chk($sformatf("v%0d_ack", r),     32'(req_ack),     32'(tbl[r].e_ack));
            chk($sformatf("v%0d_done", r),    32'(req_done),    32'(tbl[r].e_done));
            chk($sformatf("v%0d_err", r),     32'(req_err),     32'd0);
            chk($sformatf("v%0d_ready", r),   32'(drv_ready),   32'(tbl[r].e_rdy));
            chk($sformatf("v%0d_bwr", r),     32'(drv_buff_wr), 32'(tbl[r].e_bwr));
            chk($sformatf("v%0d_mounted", r), 32'(drv_mounted), 32'(tbl[r].e_mnt));
            chk($sformatf("v%0d_din", r),     32'(sd_buff_din), 32'h11);
        end
        sd_buff_wr = 1'b0;

        // Full read on drive 0: 512 strobes inside a 600-cycle ack window.
        req_rd = 2'b01;
        step;
        chk("rd_sd_rd", 32'(sd_rd), 32'd1);
        chk("rd_sd_wr", 32'(sd_wr), 32'd0);
        chk("rd_lba", sd_lba, 32'h12);
        sd_ack = 1'b1;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 600; i++) begin
            sd_buff_wr = (i >= 20 && i < 532);
            #1;
            c0 += int'(drv_buff_wr[0]);
            c1 += int'(drv_buff_wr[1]);
            step;
        end
        sd_buff_wr = 1'b0;
        chk("rd_bwr0_count", 32'(c0), 32'd512);
        chk("rd_bwr1_count", 32'(c1), 32'd0);
        sd_ack = 1'b0;
        wait_for("rd_done", 2, 8, n);
        chk("rd_done_latency", 32'(n >= 3 && n <= 4), 32'd1);
        chk("rd_done_drv", 32'(req_done), 32'b01);
        req_rd = 2'b00;
        step;
        chk("rd_done_pulse", 32'(req_done), 32'd0);

        // Write on drive 1.
        mount(1'b1, 32'h0000_1000);
        chk("wr_ready", 32'(drv_ready), 32'b11);
        req_lba[63:32] = 32'h77;
        req_wr = 2'b10;
        step;
        chk("wr_sd_wr", 32'(sd_wr), 32'd1);
        chk("wr_sd_rd", 32'(sd_rd), 32'd0);
        chk("wr_lba", sd_lba, 32'h77);
        sd_ack = 1'b1;
        wait_for("wr_ack", 1, 8, n);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_din_%0d", i), 32'(sd_buff_din), 32'hA5);
            chk($sformatf("wr_ackdrv_%0d", i), 32'(req_ack), 32'b10);
            step;
        end
        sd_ack = 1'b0;
        wait_for("wr_done", 2, 8, n);
        chk("wr_done_drv", 32'(req_done), 32'b10);
        req_wr = 2'b00;
        step;

        // Round-robin with both drives requesting continuously.
        req_lba = {32'h200, 32'h100};
        req_rd  = 2'b11;
        do_xfer("rr0", 32'h100, 2'b01);
        do_xfer("rr1", 32'h200, 2'b10);
        do_xfer("rr2", 32'h100, 2'b01);
        do_xfer("rr3", 32'h200, 2'b10);
        req_rd = 2'b00;
        step;

        // Not-ready drive: empty image mounted on drive 1.
        mount(1'b1, 32'h0);
        chk("nr_ready", 32'(drv_ready), 32'b01);
        req_rd = 2'b10;
        never = 1'b1;
        n = 0;
        while (!req_err[1] && n < 4) begin
            step;
            n++;
            if (sd_rd || sd_wr) never = 1'b0;
        end
        chk("nr_err", 32'(req_err), 32'b10);
        chk("nr_latency", 32'(n >= 1 && n <= 2), 32'd1);
        chk("nr_no_sd_cycle", 32'(never), 32'd1);
        req_rd = 2'b00;
        step;
        chk("nr_err_pulse", 32'(req_err), 32'd0);
        chk("nr_lba_hold", sd_lba, 32'h200);
        chk("nr_no_sd_after", 32'(sd_rd | sd_wr), 32'd0);

        // Timeout on drive 0 with sd_ack held low.
        req_rd = 2'b01;
        step;
        chk("to_grant", 32'(sd_rd), 32'd1);
        n = 0;
        prev_rd = sd_rd;
        while (!req_err[0] && n < 200) begin
            prev_rd = sd_rd;
            step;
            n++;
        end
        chk("to_cycles", 32'(n), 32'd101);
        chk("to_err_drv", 32'(req_err), 32'b01);
        chk("to_rd_dropped", 32'(sd_rd), 32'd0);
        chk("to_rd_before", 32'(prev_rd), 32'd1);
        req_rd = 2'b00;
        step;

        // Reset in the middle of a transfer.
        req_lba[31:0] = 32'h55;
        req_rd = 2'b01;
        wait_for("rst_grant", 0, 8, n);
        sd_ack = 1'b1;
        wait_for("rst_in_xfer", 1, 8, n);
        reset = 1'b1;
        step;
        chk("rst_sd_rd", 32'(sd_rd | sd_wr), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_done_err", 32'({req_done, req_err}), 32'd0);
        chk("rst_ready", 32'(drv_ready), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        reset  = 1'b0;
        sd_ack = 1'b0;
        req_rd = 2'b00;
        step;
        mount(1'b1, 32'h800);
        mount(1'b0, 32'h800);
        req_rd = 2'b11;
        do_xfer("rst_first", 32'h55, 2'b01);
        req_rd = 2'b00;
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
